// File: rtl/downsample_ctrl.sv
// downsample_ctrl: Moore control FSM for 2:1 decimation of a W x H frame in both axes.
// Define DS_PERF_CNT_EN to add the 32-bit busy-cycle counter output frame_cycles.
module downsample_ctrl #(
  parameter int         MEM_RD_LAT = 2,
  parameter logic [2:0] ALU_ADD    = 3'd0,
  parameter logic [2:0] ALU_SUB    = 3'd1,
  parameter logic [2:0] ALU_INCB   = 3'd2,
  parameter logic [2:0] ALU_INCB2  = 3'd3,
  parameter logic [2:0] ALU_INCA2  = 3'd4,
  parameter logic [2:0] A_RI       = 3'd1,
  parameter logic [2:0] A_RJ       = 3'd2,
  parameter logic [2:0] A_RW       = 3'd4,
  parameter logic [2:0] B_RH       = 3'd0,
  parameter logic [2:0] B_RW       = 3'd1,
  parameter logic [2:0] B_RK       = 3'd2,
  parameter logic [2:0] B_RX       = 3'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cfg_ld_w,
  input  logic        cfg_ld_h,
  input  logic        z,
  input  logic        z1,
  output logic [2:0]  ALU_OP,
  output logic [2:0]  AMUX_sel,
  output logic [2:0]  BMUX_sel,
  output logic [8:0]  LOAD_VECT,
  output logic [5:0]  CLEAR_VECT,
  output logic        PASS_AC,
  output logic        MO_we,
  output logic        busy,
  output logic        done
`ifdef DS_PERF_CNT_EN
  ,
  output logic [31:0] frame_cycles
`endif
);

  // LOAD_VECT bit positions (register loaded by each bit)
  localparam int LV_MI = 0;
  localparam int LV_AC = 1;
  localparam int LV_RH = 2;
  localparam int LV_RW = 3;
  localparam int LV_RS = 4;
  localparam int LV_RX = 5;
  localparam int LV_RI = 6;
  localparam int LV_RJ = 7;
  localparam int LV_RK = 8;
  localparam int CV_RI = 3;

  localparam logic [2:0] RD_LAST = 3'(MEM_RD_LAT - 1);

  typedef enum logic [4:0] {
    S_IDLE = 5'd0,  S_CLR  = 5'd1,  S_RD   = 5'd2,  S_LDMI = 5'd3,
    S_LDRS = 5'd4,  S_WR   = 5'd5,  S_K1   = 5'd6,  S_K2   = 5'd7,
    S_X1   = 5'd8,  S_X2   = 5'd9,  S_I1   = 5'd10, S_I2   = 5'd11,
    S_IC   = 5'd12, S_IW   = 5'd13, S_IT   = 5'd14, S_ROW  = 5'd15,
    S_ROWX = 5'd16, S_RB   = 5'd17, S_J1   = 5'd18, S_J2   = 5'd19,
    S_JC   = 5'd20, S_JW   = 5'd21, S_JT   = 5'd22, S_DONE = 5'd23
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] rd_cnt_q, rd_cnt_d;

  logic unused_z1;
  assign unused_z1 = z1;

  // z is a registered AC==0 flag, so each loop test waits one cycle (S_IW/S_JW)
  // after the subtract before branching; S_RB is a row-turnaround bubble.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = 3'd0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CLR;
      S_CLR:  state_d = S_RD;
      S_RD: begin
        if (rd_cnt_q == RD_LAST) state_d = S_LDMI;
        else                     rd_cnt_d = rd_cnt_q + 3'd1;
      end
      S_LDMI: state_d = S_LDRS;
      S_LDRS: state_d = S_WR;
      S_WR:   state_d = S_K1;
      S_K1:   state_d = S_K2;
      S_K2:   state_d = S_X1;
      S_X1:   state_d = S_X2;
      S_X2:   state_d = S_I1;
      S_I1:   state_d = S_I2;
      S_I2:   state_d = S_IC;
      S_IC:   state_d = S_IW;
      S_IW:   state_d = S_IT;
      S_IT:   state_d = z ? S_ROW : S_RD;
      S_ROW:  state_d = S_ROWX;
      S_ROWX: state_d = S_RB;
      S_RB:   state_d = S_J1;
      S_J1:   state_d = S_J2;
      S_J2:   state_d = S_JC;
      S_JC:   state_d = S_JW;
      S_JW:   state_d = S_JT;
      S_JT:   state_d = z ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALU_OP     = 3'd0;
    AMUX_sel   = 3'd0;
    BMUX_sel   = 3'd0;
    LOAD_VECT  = 9'd0;
    CLEAR_VECT = 6'd0;
    PASS_AC    = 1'b0;
    MO_we      = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        LOAD_VECT[LV_RW] = cfg_ld_w;
        LOAD_VECT[LV_RH] = cfg_ld_h;
      end
      S_CLR:  CLEAR_VECT = 6'b111111;
      S_LDMI: LOAD_VECT[LV_MI] = 1'b1;
      S_LDRS: LOAD_VECT[LV_RS] = 1'b1;
      S_WR:   MO_we = 1'b1;
      S_K1: begin
        ALU_OP = ALU_INCB; BMUX_sel = B_RK; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_K2:   LOAD_VECT[LV_RK] = 1'b1;
      S_X1: begin
        ALU_OP = ALU_INCB2; BMUX_sel = B_RX; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_X2:   LOAD_VECT[LV_RX] = 1'b1;
      S_I1: begin
        ALU_OP = ALU_INCA2; AMUX_sel = A_RI; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_I2:   LOAD_VECT[LV_RI] = 1'b1;
      S_IC: begin
        ALU_OP = ALU_SUB; AMUX_sel = A_RI; BMUX_sel = B_RW; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_ROW: begin
        ALU_OP = ALU_ADD; AMUX_sel = A_RW; BMUX_sel = B_RX; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_ROWX: begin
        LOAD_VECT[LV_RX] = 1'b1; CLEAR_VECT[CV_RI] = 1'b1;
      end
      S_J1: begin
        ALU_OP = ALU_INCA2; AMUX_sel = A_RJ; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_J2:   LOAD_VECT[LV_RJ] = 1'b1;
      S_JC: begin
        ALU_OP = ALU_SUB; AMUX_sel = A_RJ; BMUX_sel = B_RH; LOAD_VECT[LV_AC] = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

`ifdef DS_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE) begin
      if (start) cyc_d = 32'd0;
    end else begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  assign frame_cycles = cyc_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= 3'd0;
`ifdef DS_PERF_CNT_EN
      cyc_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
`ifdef DS_PERF_CNT_EN
      cyc_q    <= cyc_d;
`endif
    end
  end

endmodule

// File: tb/tb_downsample_ctrl.sv
// tb_downsample_ctrl: drives downsample_ctrl with a small datapath/memory environment and
// compares write streams and timing against an arithmetic decimation model.
module tb_downsample_ctrl;

  localparam int LAT    = 2;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cfg_ld_w = 1'b0;
  logic       cfg_ld_h = 1'b0;
  logic       z;
  logic       z1 = 1'b0;
  logic [2:0] alu_op, amux_sel, bmux_sel;
  logic [8:0] load_vect;
  logic [5:0] clear_vect;
  logic       pass_ac, mo_we, busy, done;
`ifdef DS_PERF_CNT_EN
  logic [31:0] frame_cycles;
`endif

  int checks = 0;
  int failures = 0;
  int pass_seen = 0;

  downsample_ctrl #(.MEM_RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_ld_w   (cfg_ld_w),
    .cfg_ld_h   (cfg_ld_h),
    .z          (z),
    .z1         (z1),
    .ALU_OP     (alu_op),
    .AMUX_sel   (amux_sel),
    .BMUX_sel   (bmux_sel),
    .LOAD_VECT  (load_vect),
    .CLEAR_VECT (clear_vect),
    .PASS_AC    (pass_ac),
    .MO_we      (mo_we),
    .busy       (busy),
    .done       (done)
`ifdef DS_PERF_CNT_EN
    ,
    .frame_cycles (frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Environment: register file, ALU, latency-delayed input memory, output capture.
  logic [7:0] mi_mem [0:255];
  logic [7:0] ac = 8'd0, rs = 8'd0, rx = 8'd0, ri = 8'd0, rj = 8'd0, rk = 8'd0;
  logic [7:0] rw = 8'd0, rh = 8'd0, cfg_data = 8'd0;
  logic       z_q = 1'b0;
  logic [7:0] addr_pipe [0:7];
  logic [7:0] alu_a, alu_b, alu_c, mi_data;
  int         wr_addr_q[$];
  int         wr_data_q[$];

  assign z = z_q;

  always_comb begin
    alu_a = 8'd0;
    case (amux_sel)
      3'd1: alu_a = ri;
      3'd2: alu_a = rj;
      3'd4: alu_a = rw;
      default: ;
    endcase
    alu_b = rh;
    case (bmux_sel)
      3'd1: alu_b = rw;
      3'd2: alu_b = rk;
      3'd3: alu_b = rx;
      default: ;
    endcase
    alu_c = 8'd0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_b + 8'd1;
      3'd3: alu_c = alu_b + 8'd2;
      3'd4: alu_c = alu_a + 8'd2;
      default: ;
    endcase
    mi_data = mi_mem[addr_pipe[LAT-1]];
  end

  always @(posedge clk) begin
    z1 <= ~z1;
    addr_pipe[0] <= rx;
    for (int k = 1; k < 8; k++) addr_pipe[k] <= addr_pipe[k-1];
    z_q <= (ac == 8'd0);
    if (clear_vect[0]) ac <= 8'd0;
    else if (load_vect[1]) ac <= alu_c;
    else if (load_vect[0]) ac <= mi_data;
    if (clear_vect[1]) rs <= 8'd0; else if (load_vect[4]) rs <= ac;
    if (clear_vect[2]) rx <= 8'd0; else if (load_vect[5]) rx <= ac;
    if (clear_vect[3]) ri <= 8'd0; else if (load_vect[6]) ri <= ac;
    if (clear_vect[4]) rj <= 8'd0; else if (load_vect[7]) rj <= ac;
    if (clear_vect[5]) rk <= 8'd0; else if (load_vect[8]) rk <= ac;
    if (load_vect[3]) rw <= cfg_data;
    if (load_vect[2]) rh <= cfg_data;
    if (mo_we) begin
      wr_addr_q.push_back(int'(rk));
      wr_data_q.push_back(int'(rs));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input int w, input int h);
    return 2 + (w / 2) * (h / 2) * (LAT + 12) + (h / 2) * 8;
  endfunction

  task automatic load_cfg(input int w, input int h);
    @(negedge clk); cfg_data = 8'(w); cfg_ld_w = 1'b1; #1;
    check("ld_w_idle", load_vect, 9'h008);
    @(negedge clk); cfg_ld_w = 1'b0; cfg_data = 8'(h); cfg_ld_h = 1'b1; #1;
    check("ld_h_idle", load_vect, 9'h004);
    @(negedge clk); cfg_ld_h = 1'b0;
  endtask

  // Compare captured writes (from queue offset base) with the decimated frame.
  task automatic verify_writes(input string tag, input int w, input int h, input int base);
    int exp_data[$];
    for (int r = 0; r < h; r += 2)
      for (int c = 0; c < w; c += 2)
        exp_data.push_back(int'(mi_mem[r * w + c]));
    for (int i = 0; i < exp_data.size(); i++) begin
      if (base + i < wr_addr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wr_addr_q[base + i], i);
        check($sformatf("%s_data%0d", tag, i), wr_data_q[base + i], exp_data[i]);
      end
    end
  endtask

  // Start one frame, run to done; optionally poke start/cfg_ld_w at busy cycle poke_at.
  task automatic run_frame(input string tag, input int poke_at, output int cyc, output int n_done);
    int guard;
    bit poked;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_clr_busy"}, busy, 1);
    check({tag, "_clr_vect"}, clear_vect, 6'h3f);
    cyc = 1; n_done = 0; guard = 0; poked = 0;
    while (n_done == 0 && guard < BUDGET) begin
      @(negedge clk); guard++;
      if (poked) begin start = 1'b0; cfg_ld_w = 1'b0; poked = 0; end
      if (busy) cyc++;
      if (pass_ac) pass_seen = 1;
      if (done) n_done++;
      if (cyc == poke_at && busy && !done) begin
        start = 1'b1; cfg_ld_w = 1'b1; poked = 1; #1;
        check({tag, "_ld_w_busy"}, load_vect[3], 0);
      end
    end
    if (guard >= BUDGET) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    start = 1'b0; cfg_ld_w = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    repeat (3) @(negedge clk);
    check({tag, "_no_restart"}, busy, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nd, guard, nwe, w, h;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mo_we", mo_we, 0);
    check("rst_load", load_vect, 0);
    check("rst_clear", clear_vect, 0);
`ifdef DS_PERF_CNT_EN
    check("rst_frame_cycles", frame_cycles, 0);
`endif
    rst_n = 1'b1;

    // 4x4 frame with MI[a]=a
    for (int a = 0; a < 256; a++) mi_mem[a] = 8'(a);
    load_cfg(4, 4);
    run_frame("f44", -1, cyc, nd);
    $display("frame w=4 h=4 writes=%0d cycles=%0d", wr_addr_q.size(), cyc);
    check("f44_dones", nd, 1);
    check("f44_cycles", cyc, 74);
    check("f44_wr_count", wr_addr_q.size(), 4);
    verify_writes("f44", 4, 4, 0);
`ifdef DS_PERF_CNT_EN
    check("f44_frame_cycles", frame_cycles, 74);
`endif

    // 2x2 frame: single write, done on busy cycle 24
    for (int a = 0; a < 256; a++) mi_mem[a] = 8'($urandom);
    load_cfg(2, 2);
    run_frame("f22", -1, cyc, nd);
    $display("frame w=2 h=2 writes=%0d cycles=%0d", wr_addr_q.size(), cyc);
    check("f22_dones", nd, 1);
    check("f22_cycles", cyc, 24);
    check("f22_wr_count", wr_addr_q.size(), 1);
    verify_writes("f22", 2, 2, 0);

    // start and cfg_ld_w poked while busy
    load_cfg(4, 4);
    run_frame("poke", 20, cyc, nd);
    $display("frame w=4 h=4 poked writes=%0d cycles=%0d", wr_addr_q.size(), cyc);
    check("poke_dones", nd, 1);
    check("poke_cycles", cyc, 74);
    check("poke_wr_count", wr_addr_q.size(), 4);
    verify_writes("poke", 4, 4, 0);

    // Asynchronous reset during the third write cycle, then a clean frame
    wr_addr_q.delete(); wr_data_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0; nwe = 0;
    while (nwe < 3 && guard < BUDGET) begin
      @(negedge clk); guard++;
      if (mo_we) nwe++;
    end
    check("rst_mid_reach_wr3", nwe, 3);
    rst_n = 1'b0; #1;
    check("rst_mid_mo_we", mo_we, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_load", load_vect, 0);
    check("rst_mid_alu", {alu_op, amux_sel, bmux_sel}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_partial", wr_addr_q.size(), 2);
    $display("reset mid-frame after writes=%0d", wr_addr_q.size());
    run_frame("after_rst", -1, cyc, nd);
    $display("frame w=4 h=4 after reset writes=%0d cycles=%0d", wr_addr_q.size(), cyc);
    check("after_rst_dones", nd, 1);
    check("after_rst_wr_count", wr_addr_q.size(), 4);
    verify_writes("after_rst", 4, 4, 0);

    // start held high: two back-to-back 4x2 frames
    for (int a = 0; a < 256; a++) mi_mem[a] = 8'($urandom);
    load_cfg(4, 2);
    wr_addr_q.delete(); wr_data_q.delete();
    nd = 0; guard = 0;
    @(negedge clk); start = 1'b1;
    while (nd < 2 && guard < BUDGET) begin
      @(negedge clk); guard++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          @(negedge clk); guard++;
          check("b2b_gap_idle", busy, 0);
          @(negedge clk); guard++;
          check("b2b_retrigger", clear_vect, 6'h3f);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (guard >= BUDGET) check("b2b_timeout", 0, 1);
    $display("back-to-back frames dones=%0d writes=%0d", nd, wr_addr_q.size());
    check("b2b_dones", nd, 2);
    check("b2b_wr_count", wr_addr_q.size(), 4);
    verify_writes("b2b_first", 4, 2, 0);
    verify_writes("b2b_second", 4, 2, 2);
    repeat (3) @(negedge clk);
    check("b2b_stopped", busy, 0);

    // Randomized frame sizes and contents
    for (int f = 0; f < 5; f++) begin
      w = 2 * int'($urandom_range(1, 4));
      h = 2 * int'($urandom_range(1, 4));
      for (int a = 0; a < 256; a++) mi_mem[a] = 8'($urandom);
      load_cfg(w, h);
      run_frame($sformatf("rnd%0d", f), -1, cyc, nd);
      $display("frame w=%0d h=%0d writes=%0d cycles=%0d", w, h, wr_addr_q.size(), cyc);
      check($sformatf("rnd%0d_dones", f), nd, 1);
      check($sformatf("rnd%0d_cycles", f), cyc, exp_cycles(w, h));
      check($sformatf("rnd%0d_wr_count", f), wr_addr_q.size(), (w / 2) * (h / 2));
      verify_writes($sformatf("rnd%0d", f), w, h, 0);
`ifdef DS_PERF_CNT_EN
      check($sformatf("rnd%0d_frame_cycles", f), frame_cycles, exp_cycles(w, h));
`endif
    end

    check("pass_ac_never", pass_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/downsample_ctrl.md
DOWNSAMPLE_CTRL -- requirements
Module: downsample_ctrl

Interface
REQ-001 Parameter MEM_RD_LAT, default 2, MI read latency in cycles (1..7) from MI_add change to valid MI_data.
REQ-002 Parameters ALU_ADD 3'd0 (C=A+B), ALU_SUB 3'd1 (C=A-B), ALU_INCB 3'd2 (C=B+1), ALU_INCB2 3'd3 (C=B+2), ALU_INCA2 3'd4 (C=A+2): ALU_OP codes.
REQ-003 Parameters A_RI 3'd1, A_RJ 3'd2, A_RW 3'd4; B_RH 3'd0, B_RW 3'd1, B_RK 3'd2, B_RX 3'd3: AMUX_sel/BMUX_sel codes.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin one frame; sampled only in S_IDLE.
REQ-007 cfg_ld_w, cfg_ld_h  input  1 each  host load strobes for RW/RH, forwarded only in S_IDLE.
REQ-008 z  input  1  AC==0 flag; z1  input  1  reserved, ignored.
REQ-009 ALU_OP, AMUX_sel, BMUX_sel  output  3 each; LOAD_VECT  output  9; CLEAR_VECT  output  6; PASS_AC  output  1: datapath controls.
REQ-010 MO_we  output  1  output-memory write strobe (data RS, address RK).
REQ-011 busy  output  1  high in every state except S_IDLE; done  output  1  one-cycle pulse at frame end.

Function
REQ-012 Operation: 2:1 decimation in both axes of a W x H frame (W=RW, H=RH, both even, >=2); reads MI at even row/even column, writes (W/2)*(H/2) bytes to MO addresses 0..N-1 in raster order.
REQ-013 All control outputs registered-free Moore decode of state; any field not listed for a state SHALL be 0.
REQ-014 S_IDLE: LOAD_VECT[3]=cfg_ld_w, LOAD_VECT[2]=cfg_ld_h; start=1 -> S_CLR next cycle. LOAD_VECT[3:2]=0 in all other states.
REQ-015 S_CLR: CLEAR_VECT=6'b111111 (AC,RS,RX,RI,RJ,RK) -> S_RD.
REQ-016 S_RD: internal 3-bit counter counts MEM_RD_LAT cycles (cleared on entry) -> S_LDMI after the last.
REQ-017 S_LDMI: LOAD_VECT[0]=1 -> S_LDRS: LOAD_VECT[4]=1 -> S_WR: MO_we=1 -> S_K1.
REQ-018 S_K1: ALU_INCB, B_RK, LOAD_VECT[1] -> S_K2: LOAD_VECT[8] -> S_X1: ALU_INCB2, B_RX, LOAD_VECT[1] -> S_X2: LOAD_VECT[5].
REQ-019 S_I1: ALU_INCA2, A_RI, LOAD_VECT[1] -> S_I2: LOAD_VECT[6] -> S_IC: ALU_SUB, A_RI, B_RW, LOAD_VECT[1] -> S_IT.
REQ-020 S_IT: z=1 -> S_ROW, else S_RD.
REQ-021 S_ROW: ALU_ADD, A_RW, B_RX, LOAD_VECT[1] -> S_ROWX: LOAD_VECT[5], CLEAR_VECT[3] (skip odd row, reset RI).
REQ-022 S_J1: ALU_INCA2, A_RJ, LOAD_VECT[1] -> S_J2: LOAD_VECT[7] -> S_JC: ALU_SUB, A_RJ, B_RH, LOAD_VECT[1] -> S_JT: z=1 -> S_DONE, else S_RD.
REQ-023 S_DONE: done=1 for exactly one cycle -> S_IDLE.
REQ-024 Per output pixel: MEM_RD_LAT+12 cycles; extra 8 cycles per row end; PASS_AC=0 always.
REQ-025 start while busy ignored; start held high re-triggers one cycle after done.
REQ-026 Undefined state encodings SHALL return to S_IDLE next cycle.

Reset
REQ-027 rst_n=0 asynchronously forces S_IDLE, read counter 0, all outputs 0 (busy=0, done=0, MO_we=0), including mid-frame; no datapath clear issued by reset.
REQ-028 First start after reset release behaves as from power-up.

Configuration
REQ-029 Macro DS_PERF_CNT_EN defined: extra output frame_cycles (32-bit), cleared on S_CLR entry, increments each busy cycle, holds after done, reset 0; wraps at 2^32.
REQ-030 DS_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 W=4,H=4, MEM_RD_LAT=2, MI[a]=a -> 4 MO_we pulses, MO_add 0,1,2,3 with data 0,2,8,10; done once.
REQ-032 W=2,H=2 -> exactly one write (addr 0, data MI[0]); done at cycle 1+1+(2+12)+8 after start accepted.
REQ-033 Assert rst_n low during third S_WR of W=H=4 frame -> outputs 0 same cycle; new start completes full 4-write frame.
REQ-034 start pulsed during busy -> no restart, write count unchanged; start held high -> back-to-back frames, one done each.
REQ-035 cfg_ld_w=1 while busy -> LOAD_VECT[3]=0; in S_IDLE -> LOAD_VECT[3]=1 same cycle.
REQ-036 DS_PERF_CNT_EN defined, W=H=4, MEM_RD_LAT=2 -> frame_cycles = 1+4*14+2*8+1 = 74 after done.
